// File: rtl/regfile_bist_pkg.sv
// Shared types and helpers for the register-file BIST initiator.
// Consumed by regfile_bist_ctrl and regfile_bist_addr_ctr.
package regfile_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NPHASES  = 4;
    localparam int EXP_MAXW = 32;

    // Expected entry value: pattern xor address, inverted on the second pass.
    // Callers pass zero-extended operands and keep the low nbits of the result.
    function automatic logic [EXP_MAXW-1:0] exp_data(
        input logic                p,
        input logic [EXP_MAXW-1:0] pat,
        input logic [EXP_MAXW-1:0] addr,
        input int                  nbits
    );
        logic [EXP_MAXW-1:0] mask;
        mask = (nbits >= EXP_MAXW) ? '1 : ((EXP_MAXW'(1) << nbits) - EXP_MAXW'(1));
        return (p ? ~(pat ^ addr) : (pat ^ addr)) & mask;
    endfunction

endpackage

// File: rtl/regfile_bist_addr_ctr.sv
// Address walk counter: clear, enable, and a flag marking the last entry.
module regfile_bist_addr_ctr #(
    parameter int AW   = 2,
    parameter int LAST = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          last
);
    import regfile_bist_pkg::*;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + AW'(1);
        end
    end

    assign last = (cnt == AW'(LAST));

endmodule

// File: rtl/regfile_bist_ctrl.sv
// BIST initiator for a 1R/1W register file: write/read-back walk, true then inverted data.
// Build option: REGFILE_BIST_STOP_ON_FAIL_EN ends the run at the first read mismatch.
module regfile_bist_ctrl
    import regfile_bist_pkg::*;
#(
    parameter int  NREGS = 4,
    parameter int  NBITS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] pattern,
    output logic             rf_wen,
    output logic [AW-1:0]    rf_waddr,
    output logic [NBITS-1:0] rf_wdata,
    output logic [AW-1:0]    rf_raddr,
    input  logic [NBITS-1:0] rf_rdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW-1:0]    fail_addr
);

`ifdef REGFILE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam int          PW      = $clog2(NPHASES);
    localparam logic [PW-1:0] PH_LAST = PW'(NPHASES - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    addr;
    logic             addr_last;
    logic [PW-1:0]    phase;
    logic [NBITS-1:0] pat_q;
    logic [NBITS-1:0] exp_d;
    logic             fail_q;
    logic [AW-1:0]    fail_addr_q;
    logic             start_acc;
    logic             walking;
    logic             mismatch;

    assign start_acc = ((state == IDLE) || (state == DONE)) && start;
    assign walking   = (state == WR) || (state == RD);

    // Phase bit 1 selects the inverted-data pass; bit 0 is write vs read.
    assign exp_d    = NBITS'(exp_data(phase[PW-1], EXP_MAXW'(pat_q), EXP_MAXW'(addr), NBITS));
    assign mismatch = (state == RD) && (rf_rdata != exp_d);

    regfile_bist_addr_ctr #(
        .AW   (AW),
        .LAST (NREGS - 1)
    ) u_addr_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .en   (walking),
        .cnt  (addr),
        .last (addr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = WR;
            WR:         if (addr_last) state_nxt = RD;
            RD: begin
                if (addr_last) state_nxt = (phase == PH_LAST) ? DONE : WR;
                if (STOP_ON_FAIL && mismatch) state_nxt = DONE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            pat_q       <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else if (start_acc) begin
            phase       <= '0;
            pat_q       <= pattern;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            if (walking && addr_last) phase <= phase + PW'(1);
            // Only the first mismatch of a run is recorded.
            if (mismatch && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= addr;
            end
        end
    end

    always_comb begin
        rf_wen    = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_raddr  = '0;
        busy      = walking;
        done      = (state == DONE);
        pass      = (state == DONE) && !fail_q;
        fail_addr = fail_addr_q;
        if (state == WR) begin
            rf_wen   = 1'b1;
            rf_waddr = addr;
            rf_wdata = exp_d;
        end
        if (state == RD) begin
            rf_raddr = addr;
        end
    end

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Bench for regfile_bist_ctrl: case table plus scoreboard of per-cycle port activity.
module tb_regfile_bist_ctrl;

`ifdef REGFILE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = 4'h0;
    logic       rf_wen;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic [1:0] rf_raddr;
    logic [3:0] rf_rdata;
    logic       busy, done, pass;
    logic [1:0] fail_addr;

    logic [3:0] mem [4];
    bit         stuck = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] pat;
        bit         stuck;
        bit         start_busy;
        bit         exp_pass;
        logic [1:0] exp_faddr;
        int         done_cyc;
    } case_t;

    // {busy, done, rf_wen, rf_waddr, rf_wdata, rf_raddr}
    logic [10:0] sb_q [$];

    always #5 clk = ~clk;

    regfile_bist_ctrl #(.NREGS(4), .NBITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr)
    );

    always_ff @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
    end

    always_comb begin
        rf_rdata = mem[rf_raddr];
        if (stuck && rf_raddr == 2'd2) rf_rdata[0] = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push_run(input logic [3:0] pat);
        logic [3:0] d;
        logic [1:0] ia;
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 4; i++) begin
                ia = 2'(i);
                d  = pat ^ {2'b00, ia};
                if (ph >= 2) d = ~d;
                if (ph % 2 == 0) sb_q.push_back({1'b1, 1'b0, 1'b1, ia, d, 2'b00});
                else             sb_q.push_back({1'b1, 1'b0, 1'b0, 2'b00, 4'h0, ia});
            end
        end
    endtask

    task automatic run_case(input case_t c, input int idx);
        logic [10:0] e;
        logic [10:0] obs;
        stuck   = c.stuck;
        pattern = c.pat;
        sb_q.delete();
        push_run(c.pat);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= c.done_cyc; j++) begin
            obs = {busy, done, rf_wen, rf_waddr, rf_wdata, rf_raddr};
            if (j < c.done_cyc) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("c%0d_sb_empty_j%0d", idx, j), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("c%0d_port_j%0d", idx, j), 32'(obs), 32'(e));
                end
            end else begin
                chk($sformatf("c%0d_done", idx), {29'd0, done, busy, rf_wen}, 32'b100);
                chk($sformatf("c%0d_pass", idx), 32'(pass), 32'(c.exp_pass));
                chk($sformatf("c%0d_faddr", idx), 32'(fail_addr), 32'(c.exp_faddr));
            end
            start   = c.start_busy && (j == 3 || j == 9);
            pattern = (c.start_busy && (j == 3 || j == 9)) ? ~c.pat : c.pat;
            if (j < c.done_cyc) @(negedge clk);
        end
        start = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        chk($sformatf("c%0d_done_held", idx), {30'd0, done, pass}, {30'd0, 1'b1, c.exp_pass});
    endtask

    case_t cases [6];

    initial begin
        cases[0] = '{pat: 4'h0, stuck: 1'b0, start_busy: 1'b0, exp_pass: 1'b1, exp_faddr: 2'd0, done_cyc: 16};
        cases[1] = '{pat: 4'h0, stuck: 1'b1, start_busy: 1'b0, exp_pass: 1'b0, exp_faddr: 2'd2,
                     done_cyc: STOP ? 15 : 16};
        cases[2] = '{pat: 4'h3, stuck: 1'b0, start_busy: 1'b0, exp_pass: 1'b1, exp_faddr: 2'd0, done_cyc: 16};
        cases[3] = '{pat: 4'h5, stuck: 1'b0, start_busy: 1'b1, exp_pass: 1'b1, exp_faddr: 2'd0, done_cyc: 16};
        cases[4] = '{pat: 4'hf, stuck: 1'b1, start_busy: 1'b0, exp_pass: 1'b0, exp_faddr: 2'd2,
                     done_cyc: STOP ? 7 : 16};
        cases[5] = '{pat: 4'ha, stuck: 1'b0, start_busy: 1'b0, exp_pass: 1'b1, exp_faddr: 2'd0, done_cyc: 16};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("reset_idle_%0d", k),
                32'({busy, done, pass, rf_wen, rf_waddr, rf_wdata, rf_raddr, fail_addr}), 32'd0);
        end

        for (int n = 0; n < 6; n++) run_case(cases[n], n);

        // Reset in the middle of the first read pass.
        pattern = 4'h0;
        stuck   = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrun_in_rd0", 32'({busy, rf_wen}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_idle",
            32'({busy, done, pass, rf_wen, rf_waddr, rf_wdata, rf_raddr, fail_addr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_stays_idle", 32'({busy, done}), 32'd0);
        run_case(cases[0], 10);

        // rst and start together from DONE: reset takes priority.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_beats_start", 32'({busy, done, rf_wen}), 32'd0);
        @(negedge clk);
        chk("rst_beats_start_after", 32'({busy, done}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_bist_ctrl.md
Name: regfile_bist_ctrl

Overview:
Built-in self-test initiator for the team's flat 1-read/1-write register files. It is the requester side of the regfile write/read port: it drives wen/waddr/wdata/raddr, samples the combinational rdata, and reports pass/fail. It sits between a top-level test harness (start/pattern in, status out) and one regfile instance. It runs a two-pass walk: write all entries, then read back and check all entries, once with true data and once with inverted data.

Parameters:
NREGS, 4, number of regfile entries (power of 2, at least 2)
NBITS, 4, data width of each entry
AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin a test run; sampled in IDLE or DONE only
pattern  input  NBITS  seed pattern; captured when start is accepted
rf_wen  output  1  regfile write enable
rf_waddr  output  AW  regfile write address
rf_wdata  output  NBITS  regfile write data
rf_raddr  output  AW  regfile read address
rf_rdata  input  NBITS  regfile read data (combinational from rf_raddr)
busy  output  1  run in progress
done  output  1  run finished; held until the next accepted start or rst
pass  output  1  valid when done: 1 means no mismatch
fail_addr  output  AW  address of the first mismatch; 0 if none

Behaviour:
- Reset: state=IDLE, addr=0, pass index=0, captured pattern=0, fail flag=0, fail_addr=0. All outputs 0.
- States: IDLE, WR, RD, DONE. Pass index p is 0 or 1. Address counter addr runs 0..NREGS-1.
- Expected data: exp(p,addr) = (pat ^ zero-extend(addr)), inverted when p=1.
- IDLE/DONE: if start=1 at a posedge, go to WR with p=0 and addr=0. Capture pattern. Clear the fail flag, fail_addr, and done.
- WR: rf_wen=1, rf_waddr=addr, rf_wdata=exp(p,addr). When addr=NREGS-1, go to RD with addr=0; otherwise addr increments.
- RD: rf_wen=0, rf_raddr=addr. In the same cycle compare rf_rdata with exp(p,addr). On the first mismatch, register the fail flag and fail_addr=addr at the posedge; later mismatches do not overwrite them. At addr=NREGS-1: if p=0, go to WR with p=1 and addr=0; if p=1, go to DONE.
- Outputs are Moore-style, decoded from registered state and counters only. rf_raddr=0 and rf_wdata=0 outside RD/WR respectively.
- busy=1 in WR and RD. done=1 in DONE. pass = done && !fail flag.
- Latency: if start is accepted at edge E0, the WR0/RD0/WR1/RD1 phases each take NREGS cycles and done=1 after edge E0+4*NREGS (16 cycles for the default).
- start while busy is ignored.
- A write followed by a read of the same address is never in the same cycle, so there is no read-during-write hazard.
- rst mid-run: the next state is IDLE with all outputs 0. Regfile contents are left as-is, and the next run rewrites every entry before reading.
- rst and start asserted together: rst wins.

Optional Feature:
REGFILE_BIST_STOP_ON_FAIL_EN
- Defined: the first mismatch in RD sends the FSM straight to DONE at that posedge, with pass=0 and fail_addr set.
- Undefined: the run always completes all four phases; only the first failure is reported.

Decomposition:
- Package regfile_bist_pkg holds:
  - the state enum {IDLE, WR, RD, DONE} (2-bit);
  - localparam phase count 4;
  - an exp-data function parameterised by NBITS/AW.
- One natural sub-module: regfile_bist_addr_ctr, an AW-bit counter with clear, enable, and a wrap/last flag. It is reused for the address walk.

Test Plan:
1. Reset held 2 cycles, then idle 3 cycles -> busy=done=pass=0, rf_wen=0, fail_addr=0.
2. Good 4x4b regfile, pattern=4'h0, start for 1 cycle:
   - writes 0,1,2,3, then reads 0,1,2,3; writes f,e,d,c, then reads f,e,d,c;
   - done=1 and pass=1 exactly 16 cycles after start; fail_addr=0.
3. Behavioural regfile with entry 2 bit 0 stuck at 0, pattern=4'h0:
   - pass0 is clean; pass1 reads 4'hc for expected 4'hd.
   - Without the macro: done at cycle 16, pass=0, fail_addr=2.
   - With the macro: done visible at cycle 15 (after the RD1 addr-2 edge).
4. pattern=4'h5 with start re-asserted at cycles 3 and 9 while busy -> ignored; sequence is 5,4,7,6 then a,b,8,9; done at 16, pass=1.
5. rst asserted at cycle 6 (inside RD0) -> next cycle state=IDLE, busy=0, rf_wen=0. A later start runs a full 16-cycle run that passes.
6. In DONE with pass=0, start with pattern=4'h3 -> done drops next cycle, fail flag cleared. A good regfile gives pass=1 at 16 cycles.
